// File: rtl/stopwatch_ctrl_pkg.sv
// Shared types and constants for the stopwatch controller.
// Holds the FSM state type, BCD digit geometry and the decade increment helper.
package stopwatch_ctrl_pkg;

    localparam int DIGIT_W = 4;
    localparam int DIGIT_N = 4;
    localparam logic [DIGIT_W-1:0] BCD_MAX = 4'd9;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_PAUSE,
        S_DONE
    } sw_state_e;

    function automatic logic [DIGIT_W-1:0] bcd_inc(
        input logic [DIGIT_W-1:0] v
    );
        return (v == BCD_MAX) ? '0 : v + 1'b1;
    endfunction

endpackage

// File: rtl/stopwatch_ctrl_bcd_digit.sv
// One BCD decade: counts 0..9 when en is high, carry out on 9 -> 0.
// Ports: clk, clr_n (sync active-low clear), en, q (digit), co (carry out).
module bcd_digit
    import stopwatch_ctrl_pkg::*;
(
    input  logic               clk,
    input  logic               clr_n,
    input  logic               en,
    output logic [DIGIT_W-1:0] q,
    output logic               co
);

    logic [DIGIT_W-1:0] q_q;
    logic [DIGIT_W-1:0] q_d;

    always_comb begin
        q_d = q_q;
        if (en) begin
            q_d = bcd_inc(q_q);
        end
    end

    always_ff @(posedge clk) begin
        if (!clr_n) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q  = q_q;
    // Carry is combinational so the whole ripple settles in one cycle.
    assign co = en && (q_q == BCD_MAX);

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch controller: 00.00..99.99 BCD counter, run/pause FSM, limit stop, alarm.
// Ports: fclk, reset (sync active-low), tick, key_ss, key_clr, limit_en, limit,
//        digits, running, done, wrap, alarm.
module stopwatch_ctrl
    import stopwatch_ctrl_pkg::*;
#(
    parameter int ALARM_CYCLES = 8
) (
    input  logic        fclk,
    input  logic        reset,
    input  logic        tick,
    input  logic        key_ss,
    input  logic        key_clr,
    input  logic        limit_en,
    input  logic [15:0] limit,
    output logic [15:0] digits,
    output logic        running,
    output logic        done,
    output logic        wrap,
    output logic        alarm
);

    localparam logic [7:0] ALARM_LOAD = 8'(ALARM_CYCLES);

    sw_state_e state_q, state_d;
    logic [7:0] acnt_q, acnt_d;
    logic running_q, running_d;
    logic done_q, done_d;
    logic wrap_q, wrap_d;
    logic alarm_q, alarm_d;

    logic [DIGIT_N-1:0] en;
    logic [DIGIT_N-1:0] co;
    logic [DIGIT_N*DIGIT_W-1:0] cur;
    logic [DIGIT_N*DIGIT_W-1:0] nxt;
    logic inc;
    logic hit;
    logic clr_n;

    // key_clr suppresses the increment so it wins over a coincident tick.
    assign inc   = (state_q == S_RUN) && tick && !key_clr;
    assign clr_n = reset && !key_clr;
    assign en    = {co[DIGIT_N-2:0], inc};

    for (genvar i = 0; i < DIGIT_N; i++) begin : g_dec
        bcd_digit u_digit (
            .clk   (fclk),
            .clr_n (clr_n),
            .en    (en[i]),
            .q     (cur[i*DIGIT_W +: DIGIT_W]),
            .co    (co[i])
        );
        // Value the counter will hold after this edge, used by the compare.
        assign nxt[i*DIGIT_W +: DIGIT_W] = en[i]
            ? bcd_inc(cur[i*DIGIT_W +: DIGIT_W])
            : cur[i*DIGIT_W +: DIGIT_W];
    end

    // nxt is always valid BCD, so a limit with a nibble above 9 never matches.
    assign hit = limit_en && inc && (nxt == limit);

    always_comb begin
        state_d = state_q;
        acnt_d  = acnt_q;
        if (key_clr) begin
            state_d = S_IDLE;
            acnt_d  = '0;
        end else begin
            unique case (state_q)
                S_IDLE:  if (key_ss) state_d = S_RUN;
                S_RUN: begin
                    if (hit) begin
                        state_d = S_DONE;
                    end else if (key_ss) begin
                        state_d = S_PAUSE;
                    end
                end
                S_PAUSE: if (key_ss) state_d = S_RUN;
                S_DONE:  state_d = S_DONE;
                default: state_d = S_IDLE;
            endcase
            if (hit) begin
                acnt_d = ALARM_LOAD;
            end else if (acnt_q != '0) begin
                acnt_d = acnt_q - 1'b1;
            end
        end
        running_d = (state_d == S_RUN);
        done_d    = (state_d == S_DONE);
        wrap_d    = co[DIGIT_N-1];
        alarm_d   = (acnt_d != '0);
    end

    always_ff @(posedge fclk) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            acnt_q    <= '0;
            running_q <= 1'b0;
            done_q    <= 1'b0;
            wrap_q    <= 1'b0;
            alarm_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            acnt_q    <= acnt_d;
            running_q <= running_d;
            done_q    <= done_d;
            wrap_q    <= wrap_d;
            alarm_q   <= alarm_d;
        end
    end

    assign digits  = cur;
    assign running = running_q;
    assign done    = done_q;
    assign wrap    = wrap_q;
    assign alarm   = alarm_q;

endmodule
